// File: rtl/address_sequencer.sv
// Frame-transfer sequencer: per row, copies image_width words SDRAM->SRAM row cache
// (LOAD), then SRAM output region->SDRAM (STORE), driving the address calculator.
module address_sequencer #(
    parameter int DIM_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [DIM_W-1:0] image_width,
    input  logic [DIM_W-1:0] image_height,
    input  logic             sdram_ack,
    input  logic             sram_ack,
    output logic             sdram_req,
    output logic             sram_req,
    output logic             sram_we,
    output logic             sdram_mode,
    output logic             sram_mode,
    output logic             sdram_update,
    output logic             sram_update,
    output logic             start_flag,
    output logic             busy,
    output logic             done,
    output logic [DIM_W-1:0] row_count
);

    typedef enum logic [3:0] {
        IDLE, INIT, LD_RD, LD_RD_UPD, LD_WR, LD_WR_UPD,
        ST_RD, ST_RD_UPD, ST_WR, ST_WR_UPD, ROW_END, DONE
    } state_t;

    typedef struct packed {
        logic sdram_req;
        logic sram_req;
        logic sram_we;
        logic sdram_mode;
        logic sram_mode;
        logic sdram_update;
        logic sram_update;
        logic start_flag;
        logic busy;
        logic done;
    } ctl_t;

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t           state, state_n;
    ctl_t             ctl_q;
    logic [DIM_W-1:0] width_q, height_q;
    logic [DIM_W-1:0] pix_q, pix_n, row_n;
    logic [DIM_W-1:0] pix_inc, row_inc;

    assign pix_inc = pix_q + ONE;
    assign row_inc = row_count + ONE;

    // Moore decode; mode stays put through the update cycle after each ack.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c            = '0;
        c.sdram_mode = 1'b1;
        c.sram_mode  = 1'b1;
        c.busy       = (s != IDLE);
        case (s)
            INIT:      c.start_flag   = 1'b1;
            LD_RD:     c.sdram_req    = 1'b1;
            LD_RD_UPD: c.sdram_update = 1'b1;
            LD_WR: begin
                c.sram_req = 1'b1;
                c.sram_we  = 1'b1;
            end
            LD_WR_UPD: c.sram_update = 1'b1;
            ST_RD: begin
                c.sram_req  = 1'b1;
                c.sram_mode = 1'b0;
            end
            ST_RD_UPD: begin
                c.sram_update = 1'b1;
                c.sram_mode   = 1'b0;
            end
            ST_WR: begin
                c.sdram_req  = 1'b1;
                c.sdram_mode = 1'b0;
            end
            ST_WR_UPD: begin
                c.sdram_update = 1'b1;
                c.sdram_mode   = 1'b0;
            end
            DONE:      c.done = 1'b1;
            default:   ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_n = state;
        pix_n   = pix_q;
        row_n   = row_count;
        case (state)
            IDLE:
                if (go)
                    state_n = (image_width == '0 || image_height == '0) ? DONE : INIT;
            INIT: begin
                pix_n   = '0;
                row_n   = '0;
                state_n = LD_RD;
            end
            LD_RD:     if (sdram_ack) state_n = LD_RD_UPD;
            LD_RD_UPD: state_n = LD_WR;
            LD_WR:     if (sram_ack) state_n = LD_WR_UPD;
            LD_WR_UPD:
                if (pix_inc == width_q) begin
                    pix_n   = '0;
                    state_n = ST_RD;
                end else begin
                    pix_n   = pix_inc;
                    state_n = LD_RD;
                end
            ST_RD:     if (sram_ack) state_n = ST_RD_UPD;
            ST_RD_UPD: state_n = ST_WR;
            ST_WR:     if (sdram_ack) state_n = ST_WR_UPD;
            ST_WR_UPD:
                if (pix_inc == width_q) begin
                    pix_n   = '0;
                    state_n = ROW_END;
                end else begin
                    pix_n   = pix_inc;
                    state_n = ST_RD;
                end
            ROW_END: begin
                row_n   = row_inc;
                state_n = (row_inc == height_q) ? DONE : LD_RD;
            end
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctl_q     <= decode(IDLE);
            width_q   <= '0;
            height_q  <= '0;
            pix_q     <= '0;
            row_count <= '0;
        end else begin
            state     <= state_n;
            ctl_q     <= decode(state_n);
            pix_q     <= pix_n;
            row_count <= row_n;
            if (state == IDLE && go) begin
                width_q  <= image_width;
                height_q <= image_height;
            end
        end
    end

    assign sdram_req    = ctl_q.sdram_req;
    assign sram_req     = ctl_q.sram_req;
    assign sram_we      = ctl_q.sram_we;
    assign sdram_mode   = ctl_q.sdram_mode;
    assign sram_mode    = ctl_q.sram_mode;
    assign sdram_update = ctl_q.sdram_update;
    assign sram_update  = ctl_q.sram_update;
    assign start_flag   = ctl_q.start_flag;
    assign busy         = ctl_q.busy;
    assign done         = ctl_q.done;

endmodule
